// File: rtl/gerador_paridade_serial.sv
// Framed serial transmitter: start bit 1, data LSB first, parity, stop bit 0.
// Words arrive through a valid/ready handshake and are accepted only while idle.
module gerador_paridade_serial #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CYCLES_PER_BIT = 1,
  parameter int unsigned ODD_PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dado_in,
  input  logic                  valido,
  output logic                  pronto,
  output logic                  saida_serial,
  output logic                  ocupado,
  output logic                  fim
);

  localparam int unsigned CW  = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int unsigned BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic        ODD = (ODD_PARITY != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  paridade, paridade_next;
  logic [BW-1:0]         bit_cnt, bit_cnt_next;
  logic [CW-1:0]         cyc_cnt, cyc_cnt_next;
  logic                  linha_next, fim_next;
  logic                  bit_end, bit_last;

  assign bit_end  = (cyc_cnt == CW'(CYCLES_PER_BIT - 1));
  assign bit_last = (bit_cnt == BW'(DATA_WIDTH - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_next    = state;
    shift_next    = shift_reg;
    paridade_next = paridade;
    bit_cnt_next  = bit_cnt;
    cyc_cnt_next  = bit_end ? '0 : cyc_cnt + CW'(1);

    case (state)
      IDLE: begin
        cyc_cnt_next = '0;
        bit_cnt_next = '0;
        if (valido) begin
          state_next    = START;
          shift_next    = dado_in;
          paridade_next = (^dado_in) ^ ODD;
        end
      end
      START:  if (bit_end) state_next = DATA;
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_last) begin
            bit_cnt_next = '0;
            state_next   = PARITY;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: if (bit_end) state_next = STOP;
      STOP:   if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    fim_next = (state == STOP) && bit_end;

    // The line is registered, so it is derived from where the FSM goes next.
    case (state_next)
      START:   linha_next = 1'b1;
      DATA:    linha_next = shift_next[0];
      PARITY:  linha_next = paridade_next;
      default: linha_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      paridade     <= 1'b0;
      bit_cnt      <= '0;
      cyc_cnt      <= '0;
      saida_serial <= 1'b0;
      fim          <= 1'b0;
    end else begin
      state        <= state_next;
      shift_reg    <= shift_next;
      paridade     <= paridade_next;
      bit_cnt      <= bit_cnt_next;
      cyc_cnt      <= cyc_cnt_next;
      saida_serial <= linha_next;
      fim          <= fim_next;
    end
  end

  assign pronto  = (state == IDLE);
  assign ocupado = ~pronto;

endmodule

// File: tb/tb_gerador_paridade_serial.sv
// Bench for gerador_paridade_serial: an even-parity/1-cycle instance and an
// odd-parity/4-cycle instance, checked against a queue-based frame model.
module tb_gerador_paridade_serial;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dado0, dado1;
  logic       valido0, valido1;
  logic       pronto0, ser0, ocu0, fim0;
  logic       pronto1, ser1, ocu1, fim1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gerador_paridade_serial #(.DATA_WIDTH(8), .CYCLES_PER_BIT(1), .ODD_PARITY(0)) u_par (
    .clk(clk), .reset(reset), .dado_in(dado0), .valido(valido0),
    .pronto(pronto0), .saida_serial(ser0), .ocupado(ocu0), .fim(fim0));

  gerador_paridade_serial #(.DATA_WIDTH(8), .CYCLES_PER_BIT(4), .ODD_PARITY(1)) u_impar (
    .clk(clk), .reset(reset), .dado_in(dado1), .valido(valido1),
    .pronto(pronto1), .saida_serial(ser1), .ocupado(ocu1), .fim(fim1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_of(input int which);
    return (which != 0) ? ser1 : ser0;
  endfunction
  function automatic logic pronto_of(input int which);
    return (which != 0) ? pronto1 : pronto0;
  endfunction
  function automatic logic ocu_of(input int which);
    return (which != 0) ? ocu1 : ocu0;
  endfunction
  function automatic logic fim_of(input int which);
    return (which != 0) ? fim1 : fim0;
  endfunction

  // Reference frame: start, data LSB first, parity from a popcount, stop.
  function automatic void build_frame(input logic [7:0] w, input logic odd, ref logic q[$]);
    q.push_back(1'b1);
    for (int i = 0; i < 8; i++) q.push_back(w[i]);
    q.push_back(logic'(($countones(w) % 2) != 0) ^ odd);
    q.push_back(1'b0);
  endfunction

  task automatic send(input int which, input logic [7:0] w);
    logic q[$];
    int   cpb, ones, b;
    logic odd;
    cpb  = (which != 0) ? 4 : 1;
    odd  = (which != 0);
    ones = 0;
    build_frame(w, odd, q);
    for (int n = 0; n < 200 && !pronto_of(which); n++) tick();
    check("ready_before_send", 32'(pronto_of(which)), 32'd1);
    if (which != 0) begin valido1 = 1'b1; dado1 = w; end
    else            begin valido0 = 1'b1; dado0 = w; end
    tick();
    if (which != 0) begin valido1 = 1'b0; dado1 = ~w; end
    else            begin valido0 = 1'b0; dado0 = ~w; end
    check("pronto_low_after_accept", 32'(pronto_of(which)), 32'd0);
    b = 0;
    while (q.size() > 0) begin
      logic bit_exp;
      bit_exp = q.pop_front();
      for (int c = 0; c < cpb; c++) begin
        check($sformatf("line_w%02h_b%0d_c%0d", w, b, c), 32'(line_of(which)), 32'(bit_exp));
        check("ocupado_in_frame", 32'(ocu_of(which)), 32'd1);
        if (c == 0 && b >= 1 && b <= 9 && line_of(which)) ones++;
        tick();
      end
      b++;
    end
    check("fim_at_end", 32'(fim_of(which)), 32'd1);
    check("pronto_at_end", 32'(pronto_of(which)), 32'd1);
    check("line_idle_at_end", 32'(line_of(which)), 32'd0);
    check("rx_parity_ok", 32'(ones % 2), 32'(odd));
    tick();
    check("fim_one_cycle", 32'(fim_of(which)), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic q[$];
    logic had_frame;
    logic exp_bit;

    reset = 1'b1; valido0 = 1'b0; valido1 = 1'b0; dado0 = '0; dado1 = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_line0", 32'(ser0), 32'd0);
    check("rst_pronto0", 32'(pronto0), 32'd1);
    check("rst_ocu0", 32'(ocu0), 32'd0);
    check("rst_fim0", 32'(fim0), 32'd0);
    check("rst_line1", 32'(ser1), 32'd0);
    check("rst_pronto1", 32'(pronto1), 32'd1);
    tick();

    // Directed words from the plan, then random words on both instances.
    send(0, 8'hA5);
    send(0, 8'h07);
    send(0, 8'h00);
    send(1, 8'hA5);
    for (int k = 0; k < 6; k++) begin
      send(0, 8'($urandom));
      send(1, 8'($urandom));
    end

    // valido held high with fresh data every cycle: only IDLE-cycle words go out.
    had_frame = 1'b0;
    valido0   = 1'b1;
    dado0     = 8'($urandom);
    for (int k = 0; k < 80; k++) begin
      if (q.size() == 0) begin
        check("hs_idle_line", 32'(ser0), 32'd0);
        check("hs_idle_pronto", 32'(pronto0), 32'd1);
        check("hs_fim", 32'(fim0), 32'(had_frame));
        had_frame = 1'b1;
        build_frame(dado0, 1'b0, q);
      end else begin
        exp_bit = q.pop_front();
        check($sformatf("hs_line_k%0d", k), 32'(ser0), 32'(exp_bit));
        check("hs_ocupado", 32'(ocu0), 32'd1);
        check("hs_fim_low", 32'(fim0), 32'd0);
      end
      tick();
      dado0 = 8'($urandom);
    end
    valido0 = 1'b0;
    for (int n = 0; n < 20 && !pronto0; n++) tick();
    tick();

    // Reset during data bit 3 of 0xFF.
    valido0 = 1'b1; dado0 = 8'hFF;
    tick();
    valido0 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("pre_reset_data_bit3", 32'(ser0), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_line", 32'(ser0), 32'd0);
    check("midrst_pronto", 32'(pronto0), 32'd1);
    check("midrst_fim", 32'(fim0), 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("post_rst_quiet_line", 32'(ser0), 32'd0);
      check("post_rst_no_fim", 32'(fim0), 32'd0);
    end
    send(0, 8'h3C);

    // reset and valido together in IDLE: reset wins.
    reset = 1'b1; valido0 = 1'b1; dado0 = 8'hFF;
    tick();
    reset = 1'b0; valido0 = 1'b0;
    check("rst_valido_pronto", 32'(pronto0), 32'd1);
    check("rst_valido_line", 32'(ser0), 32'd0);
    tick();
    check("rst_valido_line_next", 32'(ser0), 32'd0);
    check("rst_valido_pronto_next", 32'(pronto0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
